// File: rtl/vec_wb_wr_if.sv
// Register-file write port of the vector write-back assembler.
// The assembler drives the master side. The register file drives wr_ready.
interface vec_wb_wr_if #(
  parameter int VLEN = 128
);
  logic              wr_valid;
  logic              wr_ready;
  logic [4:0]        wr_addr;
  logic [VLEN-1:0]   wr_data;
  logic [VLEN/8-1:0] wr_be;

  modport master (output wr_valid, wr_addr, wr_data, wr_be, input wr_ready);
  modport slave  (input wr_valid, wr_addr, wr_data, wr_be, output wr_ready);
endinterface

// File: rtl/vec_wb_assembler.sv
// Merges per-lane chunk results into a VLEN-bit staging buffer with chunk byte enables.
// When all enabled lanes are done, it issues one masked register-file write.
module vec_wb_assembler #(
  parameter int VLEN       = 128,
  parameter int NB_LANES   = 4,
  parameter int LANE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start_i,
  input  logic [4:0]              vd_addr_i,
  input  logic [1:0]              nb_lanes_i,
  input  logic [NB_LANES-1:0]     lane_valid_i,
  input  logic [64*NB_LANES-1:0]  lane_data_i,
  input  logic [10*NB_LANES-1:0]  lane_index_i,
  input  logic [NB_LANES-1:0]     lane_done_i,
  vec_wb_wr_if.master             wr,
  output logic                    busy_o,
  output logic                    wb_done_o,
  output logic                    err_o
);

  localparam int CW     = 1 << LANE_WIDTH;
  localparam int CB     = CW / 8;
  localparam int NCHUNK = VLEN / CW;
  localparam int CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_e;

  state_e                     state_q;
  logic [NCHUNK-1:0][CW-1:0]  buf_q, buf_d;
  logic [NCHUNK-1:0][CB-1:0]  be_q, be_d;
  logic [NB_LANES-1:0]        done_q, done_d;
  logic [NB_LANES-1:0]        en_mask;
  logic [1:0]                 nbl_q;
  logic [4:0]                 addr_q;
  logic                       err_q, err_d;
  logic                       wb_done_q;
  logic                       all_done;

  logic [9:0]                 lane_idx [NB_LANES];
  logic [NB_LANES-1:0]        lane_ok;

  // Only the low CW bits of each lane word carry data.
  logic                       unused_lane_data;
  assign unused_lane_data = ^lane_data_i;

  always_comb begin
    for (int i = 0; i < NB_LANES; i++) begin
      en_mask[i]  = (i < (1 << nbl_q));
      lane_idx[i] = lane_index_i[i*10 +: 10];
      lane_ok[i]  = ((int'(lane_idx[i]) + CW) <= VLEN) &&
                    (lane_idx[i][LANE_WIDTH-1:0] == '0);
    end
  end

  // NOTE: every always_comb output is given its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    buf_d  = buf_q;
    be_d   = be_q;
    err_d  = err_q;
    done_d = done_q;
    if (state_q == COLLECT) begin
      done_d = done_q | (lane_done_i & en_mask);
      // Ascending loop: when two lanes hit the same chunk, the higher lane's write lands last.
      for (int i = 0; i < NB_LANES; i++) begin
        if (en_mask[i] && lane_valid_i[i]) begin
          if (lane_ok[i]) begin
            buf_d[lane_idx[i][LANE_WIDTH +: CIDX_W]] = lane_data_i[i*64 +: CW];
            be_d[lane_idx[i][LANE_WIDTH +: CIDX_W]]  = '1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  assign all_done = &(done_d | ~en_mask);

  // NOTE: the staging buffer is reset, not left undefined, because wr_data must read zero after reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      be_q      <= '0;
      done_q    <= '0;
      nbl_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      wb_done_q <= 1'b0;
    end else begin
      wb_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q <= COLLECT;
            buf_q   <= '0;
            be_q    <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            addr_q  <= vd_addr_i;
            nbl_q   <= nb_lanes_i;
          end
        end
        COLLECT: begin
          buf_q  <= buf_d;
          be_q   <= be_d;
          err_q  <= err_d;
          done_q <= done_d;
          if (all_done) state_q <= WRITE;
        end
        WRITE: begin
          if (wr.wr_ready) begin
            state_q   <= IDLE;
            wb_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr.wr_valid = (state_q == WRITE);
  assign wr.wr_addr  = addr_q;
  assign wr.wr_data  = buf_q;
  assign wr.wr_be    = be_q;
  assign busy_o      = (state_q != IDLE);
  assign wb_done_o   = wb_done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_vec_wb_assembler.sv
// Directed bench for vec_wb_assembler (VLEN=128, 4 lanes, 8-bit chunks).
// Expected values are hand-computed constants.
module tb_vec_wb_assembler;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [4:0]   vd_addr;
  logic [1:0]   nb_lanes;
  logic [3:0]   lane_valid;
  logic [255:0] lane_data;
  logic [39:0]  lane_index;
  logic [3:0]   lane_done;
  logic         busy, wb_done, err;

  int checks = 0;
  int errors = 0;

  vec_wb_wr_if #(.VLEN(128)) wr_if ();

  vec_wb_assembler #(.VLEN(128), .NB_LANES(4), .LANE_WIDTH(3)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_i      (start),
    .vd_addr_i    (vd_addr),
    .nb_lanes_i   (nb_lanes),
    .lane_valid_i (lane_valid),
    .lane_data_i  (lane_data),
    .lane_index_i (lane_index),
    .lane_done_i  (lane_done),
    .wr           (wr_if),
    .busy_o       (busy),
    .wb_done_o    (wb_done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Upper lane bits carry junk that must never reach the buffer.
  task automatic set_lane(input int i, input logic v, input logic [9:0] idx,
                          input logic [7:0] d, input logic dn);
    lane_valid[i]           = v;
    lane_data[i*64 +: 64]   = {56'hA5A5_A5A5_A5A5_A5, d};
    lane_index[i*10 +: 10]  = idx;
    lane_done[i]            = dn;
  endtask

  task automatic clear_lanes();
    lane_valid = '0;
    lane_data  = '0;
    lane_index = '0;
    lane_done  = '0;
  endtask

  task automatic do_start(input logic [4:0] a, input logic [1:0] n);
    start    = 1'b1;
    vd_addr  = a;
    nb_lanes = n;
    tick();
    start    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".wr_valid"}, 128'(wr_if.wr_valid), 128'd0);
    check({tag, ".wr_addr"},  128'(wr_if.wr_addr),  128'd0);
    check({tag, ".wr_data"},  wr_if.wr_data,        128'd0);
    check({tag, ".wr_be"},    128'(wr_if.wr_be),    128'd0);
    check({tag, ".busy"},     128'(busy),           128'd0);
    check({tag, ".wb_done"},  128'(wb_done),        128'd0);
    check({tag, ".err"},      128'(err),            128'd0);
  endtask

  initial begin
    resetn         = 1'b0;
    start          = 1'b0;
    vd_addr        = '0;
    nb_lanes       = '0;
    wr_if.wr_ready = 1'b0;
    clear_lanes();
    tick();
    tick();
    resetn = 1'b1;
    check_reset_outputs("reset");

    // Single lane, full fill; lane1 toggles junk while disabled.
    do_start(5'd5, 2'd0);
    check("t1.busy_after_start", 128'(busy), 128'd1);
    for (int k = 0; k < 16; k++) begin
      set_lane(0, 1'b1, 10'(8*k), 8'(k+1), (k == 15));
      set_lane(1, 1'b1, 10'd0, 8'hEE, 1'b1);
      tick();
      if (k == 14) check("t1.no_valid_before_done", 128'(wr_if.wr_valid), 128'd0);
    end
    clear_lanes();
    check("t1.wr_valid", 128'(wr_if.wr_valid), 128'd1);
    check("t1.wr_data",  wr_if.wr_data, 128'h100F0E0D0C0B0A090807060504030201);
    check("t1.wr_be",    128'(wr_if.wr_be), 128'hFFFF);
    check("t1.wr_addr",  128'(wr_if.wr_addr), 128'd5);
    wr_if.wr_ready = 1'b1;
    tick();
    wr_if.wr_ready = 1'b0;
    check("t1.wb_done",  128'(wb_done), 128'd1);
    check("t1.valid_drop", 128'(wr_if.wr_valid), 128'd0);
    check("t1.busy_low", 128'(busy), 128'd0);
    check("t1.data_held_idle", wr_if.wr_data, 128'h100F0E0D0C0B0A090807060504030201);
    tick();
    check("t1.wb_done_pulse", 128'(wb_done), 128'd0);

    // Four lanes, staggered dones (lane3 last), then backpressure with an ignored start.
    do_start(5'd9, 2'd2);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++)
        set_lane(i, 1'b1, 10'((4*k+i)*8), 8'(4*k+i), (i == k));
      tick();
      if (k == 2) check("t2.no_valid_before_lane3", 128'(wr_if.wr_valid), 128'd0);
    end
    clear_lanes();
    for (int c = 0; c < 5; c++) begin
      check("t2.bp_valid", 128'(wr_if.wr_valid), 128'd1);
      check("t2.bp_data",  wr_if.wr_data, 128'h0F0E0D0C0B0A09080706050403020100);
      check("t2.bp_be",    128'(wr_if.wr_be), 128'hFFFF);
      if (c == 2) begin
        start    = 1'b1;
        vd_addr  = 5'd31;
        nb_lanes = 2'd0;
      end
      tick();
      start = 1'b0;
    end
    check("t2.addr_kept", 128'(wr_if.wr_addr), 128'd9);
    check("t2.busy_in_write", 128'(busy), 128'd1);
    wr_if.wr_ready = 1'b1;
    tick();
    wr_if.wr_ready = 1'b0;
    check("t2.wb_done", 128'(wb_done), 128'd1);
    check("t2.busy_low", 128'(busy), 128'd0);
    check("t2.valid_drop", 128'(wr_if.wr_valid), 128'd0);
    tick();
    check("t2.wb_done_pulse", 128'(wb_done), 128'd0);
    check("t2.stays_idle", 128'(busy), 128'd0);

    // Partial fill, same-cycle collision and a later overwrite; lane3 disabled.
    do_start(5'd3, 2'd1);
    set_lane(0, 1'b1, 10'd0,   8'h10, 1'b0);
    set_lane(1, 1'b1, 10'd8,   8'h11, 1'b0);
    set_lane(3, 1'b1, 10'd120, 8'hFF, 1'b1);
    tick();
    clear_lanes();
    set_lane(0, 1'b1, 10'd16, 8'hAA, 1'b0);
    set_lane(1, 1'b1, 10'd16, 8'h55, 1'b0);
    tick();
    set_lane(0, 1'b1, 10'd24, 8'h13, 1'b0);
    set_lane(1, 1'b1, 10'd32, 8'h14, 1'b0);
    tick();
    set_lane(0, 1'b1, 10'd40, 8'h15, 1'b0);
    set_lane(1, 1'b1, 10'd48, 8'h16, 1'b0);
    tick();
    set_lane(0, 1'b1, 10'd56, 8'h17, 1'b1);
    set_lane(1, 1'b1, 10'd0,  8'h20, 1'b1);
    tick();
    clear_lanes();
    check("t3.wr_valid", 128'(wr_if.wr_valid), 128'd1);
    check("t3.wr_data",  wr_if.wr_data, 128'h0000000000000000_1716151413551120);
    check("t3.wr_be",    128'(wr_if.wr_be), 128'h00FF);
    check("t3.err",      128'(err), 128'd0);
    wr_if.wr_ready = 1'b1;
    tick();
    wr_if.wr_ready = 1'b0;
    check("t3.wb_done", 128'(wb_done), 128'd1);

    // Out-of-range and misaligned chunks are dropped and raise err.
    do_start(5'd7, 2'd0);
    set_lane(0, 1'b1, 10'd128, 8'h99, 1'b0);
    tick();
    check("t4.err_range", 128'(err), 128'd1);
    set_lane(0, 1'b1, 10'd12, 8'h77, 1'b0);
    tick();
    set_lane(0, 1'b1, 10'd16, 8'h42, 1'b1);
    tick();
    clear_lanes();
    check("t4.wr_valid", 128'(wr_if.wr_valid), 128'd1);
    check("t4.wr_data",  wr_if.wr_data, 128'h0000_0000_0000_0000_0000_0000_0042_0000);
    check("t4.wr_be",    128'(wr_if.wr_be), 128'h0004);
    check("t4.err_sticky", 128'(err), 128'd1);
    wr_if.wr_ready = 1'b1;
    tick();
    wr_if.wr_ready = 1'b0;
    check("t4.err_after_write", 128'(err), 128'd1);

    // Reset mid-COLLECT aborts; a fresh start then completes with wr_ready held high throughout.
    do_start(5'd12, 2'd1);
    check("t5.err_cleared_on_start", 128'(err), 128'd0);
    set_lane(0, 1'b1, 10'd0,   8'h5A, 1'b0);
    set_lane(1, 1'b1, 10'd200, 8'h3C, 1'b0);
    tick();
    clear_lanes();
    check("t5.err_before_reset", 128'(err), 128'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check_reset_outputs("t5.after_reset");
    tick();
    check("t5.no_wb_done", 128'(wb_done), 128'd0);

    wr_if.wr_ready = 1'b1;
    do_start(5'd21, 2'd0);
    set_lane(0, 1'b1, 10'd64, 8'hC3, 1'b1);
    tick();
    clear_lanes();
    check("t5.min_latency_valid", 128'(wr_if.wr_valid), 128'd1);
    check("t5.wr_data", wr_if.wr_data, 128'h0000_0000_0000_00C3_0000_0000_0000_0000);
    check("t5.wr_be",   128'(wr_if.wr_be), 128'h0100);
    check("t5.wr_addr", 128'(wr_if.wr_addr), 128'd21);
    tick();
    wr_if.wr_ready = 1'b0;
    check("t5.wb_done", 128'(wb_done), 128'd1);
    check("t5.busy_low", 128'(busy), 128'd0);
    tick();
    check("t5.wb_done_pulse", 128'(wb_done), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_wb_assembler.md
# vec_wb_assembler

Write-back assembler that sits directly downstream of the per-lane vector ALUs. Each cycle it accepts up to NB_LANES chunk results, each a data word plus destination bit index. It merges them into a VLEN-bit staging buffer with chunk-granular byte enables. Once every enabled lane has signalled done, it presents one masked write to the vector register file over a valid/ready handshake.

## Interface
Parameters:
- VLEN, 128: vector register width in bits; multiple of 64.
- NB_LANES, 4: number of lane input ports; 1, 2 or 4.
- LANE_WIDTH, 3: log2 of chunk width CW = 2^LANE_WIDTH bits; legal range 3..6.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin a write-back; honoured only in IDLE.
- vd_addr  in  5  destination vector register; latched on accepted start.
- nb_lanes  in  2  2^nb_lanes lanes are enabled, lanes 0..2^nb_lanes-1; latched on start; must satisfy 2^nb_lanes <= NB_LANES.
- lane_valid  in  NB_LANES  per-lane chunk valid.
- lane_data  in  64*NB_LANES  per-lane result; only bits [CW-1:0] are used.
- lane_index  in  10*NB_LANES  per-lane destination bit index, CW-aligned.
- lane_done  in  NB_LANES  per-lane completion strobe.
- wr_valid  out  1  register-file write request.
- wr_ready  in  1  register-file accept.
- wr_addr  out  5  destination register.
- wr_data  out  VLEN  assembled data.
- wr_be  out  VLEN/8  byte enables.
- busy  out  1  high in COLLECT and WRITE.
- wb_done  out  1  one-cycle pulse after the write is accepted.
- err  out  1  sticky: out-of-range or misaligned index seen; cleared on start.

## Operation
- FSM states: IDLE, COLLECT, WRITE.
- IDLE → COLLECT on start. On that edge:
  - buffer, byte mask and done flags are cleared;
  - err is cleared;
  - vd_addr and nb_lanes are latched.
- COLLECT, each cycle, for each enabled lane i with lane_valid[i]:
  - if idx+CW <= VLEN and idx%CW == 0, write buffer[idx +: CW] = lane_data[i][CW-1:0] and set the wr_be bits covering those CW/8 bytes;
  - otherwise drop the chunk and set err.
- Lanes that are not enabled are ignored entirely: valid, done and data.
- Two lanes targeting the same index in one cycle: the higher-numbered lane wins.
- A later write to an already-written chunk overwrites it.
- lane_done[i] sets sticky done flag i. A chunk presented in the same cycle as its lane_done is captured.
- COLLECT → WRITE on the edge after which all enabled done flags are set.
- WRITE:
  - wr_valid = 1; wr_addr, wr_data and wr_be come straight from the registers;
  - lane inputs are ignored;
  - on wr_valid && wr_ready, go to IDLE and pulse wb_done for the next cycle.
- start outside IDLE is ignored.
- The buffer holds its contents in IDLE, so wr_data stays readable. wr_valid is 0 in IDLE.

## Timing
- Reset values: state=IDLE, wr_valid=0, wr_addr=0, wr_data=0, wr_be=0, busy=0, wb_done=0, err=0. Done flags are cleared.
- Reset mid-COLLECT or mid-WRITE aborts immediately. No wb_done is produced.
- busy goes high the cycle after start.
- wr_valid goes high the cycle after the cycle in which the last enabled lane_done is sampled. Minimum latency from start to wr_valid is 2 cycles (start, then a done in the first COLLECT cycle).
- While wr_valid && !wr_ready, wr_addr, wr_data and wr_be must be held stable.
- wr_valid drops the cycle after the handshake. wb_done is high in exactly that cycle. busy is 0 in that cycle.
- No combinational path from any lane input to any output.
- wr_ready is only sampled in WRITE.

## Test plan
- **Single lane, full fill.** VLEN=128, CW=8, nb_lanes=0. Lane0 sends indices 0,8,…,120 with data 0x01..0x10, lane_done on the last. Required: wr_data=0x100F0E…0201, wr_be=16'hFFFF, wr_valid one cycle after the last done, wr_addr=vd_addr.
- **Four lanes.** nb_lanes=2. Lane i sends index (4k+i)*8 with data 4k+i, for k=0..3. Dones are staggered, with lane3 last. Required: wr_valid only after lane3's done; wr_data bytes = 0x00..0x0F in order.
- **Backpressure.** wr_ready held low for 5 cycles in WRITE. Required: wr_valid, wr_data and wr_be stable for all 5 cycles; a single wb_done pulse after wr_ready rises; busy=0 that same cycle.
- **Partial and collision.** Only indices 0..56 are written; lane0 and lane1 both hit index 16 with 0xAA and 0x55 respectively. Required: wr_be=16'h00FF, byte2=0x55, upper 64 bits of wr_data = 0.
- **Error.** Index 128 and index 12 (misaligned) are presented. Required: both chunks are dropped, err=1 until the next start, and wr_be is unaffected.
- **Reset and ignored start.** resetn is pulsed low mid-COLLECT; start is also asserted during WRITE. Required: after reset all outputs match their reset values, and a fresh start completes normally. The start during WRITE has no effect.
